// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
// Holds FSM state encoding, default sizes and a one-hot decoder.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int N_REQ_DFLT    = 5;
    localparam int MAX_HOLD_DFLT = 4;

    // Index of the set bit of a one-hot (or zero) vector, 0 if none.
    function automatic logic [4:0] onehot2idx(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr.
// Ports: req (request vector), ptr (scan start), excl_vld/excl_idx
// (one index masked out of the scan), pick_vld/pick_idx (winner).
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DFLT
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    input  logic                     excl_vld,
    input  logic [$clog2(N_REQ)-1:0] excl_idx,
    output logic                     pick_vld,
    output logic [$clog2(N_REQ)-1:0] pick_idx
);

    localparam int IW = $clog2(N_REQ);
    localparam logic [IW:0] N_W = (IW+1)'(N_REQ);

    logic [N_REQ-1:0] req_m;
    logic [N_REQ-1:0] rot;
    logic [IW-1:0]    ofs;
    logic [IW:0]      sum;

    always_comb begin
        req_m = req;
        if (excl_vld) req_m[excl_idx] = 1'b0;

        // Rotate so that bit ptr lands at position 0.
        rot = N_REQ'({req_m, req_m} >> ptr);
        pick_vld = |rot;

        ofs = '0;
        for (int i = N_REQ-1; i >= 0; i--) begin
            if (rot[i]) ofs = IW'(i);
        end

        // Rotate back: (ofs + ptr) mod N_REQ.
        sum = {1'b0, ofs} + {1'b0, ptr};
        if (sum >= N_W) sum = sum - N_W;
        pick_idx = sum[IW-1:0];
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant (no req->gnt path).
// Ports: clk, rst_n (async active-low), req[N_REQ], gnt[N_REQ],
// gnt_vld (=|gnt), gnt_id (index of set gnt bit, 0 when idle).
// Macro ARB_HOLD_LIMIT_EN: when defined, an owner is forced to hand off
// after MAX_HOLD consecutive cycles while others wait; otherwise it keeps
// the grant while its req stays high and MAX_HOLD is unused.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DFLT,
    parameter int MAX_HOLD = MAX_HOLD_DFLT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic                     gnt_vld,
    output logic [$clog2(N_REQ)-1:0] gnt_id
);

    localparam int IW = $clog2(N_REQ);
    localparam logic [IW-1:0] LAST = IW'(N_REQ-1);

    if (N_REQ < 2 || N_REQ > 32 || MAX_HOLD < 1) begin : g_bad_param
        $error("rr_arbiter: unsupported N_REQ/MAX_HOLD");
    end

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic [IW-1:0]    gnt_id_q, gnt_id_d;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD-1);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          others;
`endif

    logic          own_req;
    logic          rearb;
    logic [IW-1:0] owner_idx;
    logic          pick_vld;
    logic [IW-1:0] pick_idx;

    // gnt_q is one-hot while owning, so it identifies the owner.
    assign owner_idx = IW'(onehot2idx(32'(gnt_q)));
    assign own_req   = |(req & gnt_q);
`ifdef ARB_HOLD_LIMIT_EN
    assign others    = |(req & ~gnt_q);
`endif

    // Masking the owner only matters on a hand-off; when the owner has
    // dropped its req the mask is a no-op.
    arb_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req      (req),
        .ptr      (ptr_q),
        .excl_vld (own_req),
        .excl_idx (owner_idx),
        .pick_vld (pick_vld),
        .pick_idx (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_vld_d = gnt_vld_q;
        gnt_id_d  = gnt_id_q;
`ifdef ARB_HOLD_LIMIT_EN
        hold_cnt_d = hold_cnt_q;
`endif
        rearb = 1'b1;

        unique case (state_q)
            IDLE: rearb = 1'b1;
            OWN: begin
                if (own_req) begin
                    rearb = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
                    // Count saturates; reaching the top with others
                    // waiting forces a hand-off.
                    if (hold_cnt_q != HOLD_TOP) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end else if (others) begin
                        rearb = 1'b1;
                    end
`endif
                end
            end
            default: rearb = 1'b1;
        endcase

        if (rearb) begin
            if (pick_vld) begin
                state_d   = OWN;
                gnt_d     = N_REQ'(1) << pick_idx;
                gnt_vld_d = 1'b1;
                gnt_id_d  = pick_idx;
                ptr_d     = (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
                hold_cnt_d = '0;
`endif
            end else begin
                state_d   = IDLE;
                gnt_d     = '0;
                gnt_vld_d = 1'b0;
                gnt_id_d  = '0;
`ifdef ARB_HOLD_LIMIT_EN
                hold_cnt_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            gnt_id_q  <= '0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_id_q  <= gnt_id_d;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vld = gnt_vld_q;
    assign gnt_id  = gnt_id_q;

endmodule
